// File: rtl/mem_program_ram.sv
// Instruction RAM with power-up NOP fill, program-load port and a
// pipelined fetch port (1 or 2 cycle latency).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/ready     fetch handshake (ready only once fill is done)
//   req_addr            fetch byte address
//   rsp_valid/data/err  fetch response, no backpressure
//   load_en/addr/data   program-load write port (RUN only)
//   init_done           fill complete, block operational
module mem_program_ram #(
    parameter int          DEPTH        = 512,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] FILL_WORD    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          run;

    assign run       = (state_q == ST_RUN);
    assign req_ready = run;
    assign init_done = run;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!run) begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Fetch decode: range check on the full word index so addresses
    // beyond DEPTH never alias back into the array.
    logic [29:0]   f_widx;
    logic [AW-1:0] f_idx;
    logic          f_fire;
    logic          f_err;

    assign f_widx = req_addr[31:2];
    assign f_idx  = f_widx[AW-1:0];
    assign f_fire = req_valid & run;
    assign f_err  = (req_addr[1:0] != 2'b00) |
                    (f_widx >= 30'(DEPTH));

    // Load decode: byte offset ignored, out-of-range silently dropped.
    logic [29:0]   l_widx;
    logic          l_ok;
    logic          unused_load_lsb;

    assign l_widx          = load_addr[31:2];
    assign l_ok            = (l_widx < 30'(DEPTH));
    assign unused_load_lsb = ^load_addr[1:0];

    // Single write port shared by the init fill and program load.
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;

    assign we = run ? (load_en & l_ok) : 1'b1;
    assign wa = run ? l_widx[AW-1:0] : idx_q;
    assign wd = run ? load_data : FILL_WORD;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_q;

    // Read and write share an edge; the read returns the pre-write
    // content, giving read-before-write on a same-index collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
        if (f_fire) begin
            rd_q <= mem_q[f_idx];
        end
    end

    logic        s1_vld_q;
    logic        s1_err_q;
    logic [31:0] s1_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
        end else begin
            s1_vld_q <= f_fire;
            s1_err_q <= f_fire & f_err;
        end
    end

    assign s1_word = s1_err_q ? FILL_WORD : rd_q;

    logic        out_vld;
    logic        out_err;
    logic [31:0] out_word;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        s2_vld_q;
            logic        s2_err_q;
            logic [31:0] s2_word_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_vld_q  <= 1'b0;
                    s2_err_q  <= 1'b0;
                    s2_word_q <= '0;
                end else begin
                    s2_vld_q  <= s1_vld_q;
                    s2_err_q  <= s1_err_q;
                    s2_word_q <= s1_word;
                end
            end

            assign out_vld  = s2_vld_q;
            assign out_err  = s2_err_q;
            assign out_word = s2_word_q;
        end else begin : g_lat1
            assign out_vld  = s1_vld_q;
            assign out_err  = s1_err_q;
            assign out_word = s1_word;
        end
    endgenerate

    // Outputs are held at zero whenever no response is being presented.
    assign rsp_valid = out_vld;
    assign rsp_err   = out_vld & out_err;
    assign rsp_data  = out_vld ? out_word : '0;

endmodule

// File: doc/mem_program_ram.md
MEM_PROGRAM_RAM -- requirements
Module: mem_program_ram

Interface
REQ-001 Parameter DEPTH, 512, number of 32-bit instruction words (power of two, 16..4096).
REQ-002 Parameter READ_LATENCY, 1, cycles from request acceptance to response (legal values 1 or 2).
REQ-003 Parameter FILL_WORD, 32'h00000013, word written to every location during init (ADDI x0,x0,0 = NOP).
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port req_valid  input  1  fetch request present.
REQ-007 Port req_ready  output  1  block accepts a fetch this cycle.
REQ-008 Port req_addr  input  32  byte address of fetch.
REQ-009 Port rsp_valid  output  1  response word valid (no backpressure; consumer always takes it).
REQ-010 Port rsp_data  output  32  fetched instruction word.
REQ-011 Port rsp_err  output  1  fetch fault (misaligned or out of range), qualified by rsp_valid.
REQ-012 Port load_en  input  1  program-load write strobe.
REQ-013 Port load_addr  input  32  byte address of load write.
REQ-014 Port load_data  input  32  word to store.
REQ-015 Port init_done  output  1  init fill complete; block operational.

Function
REQ-016 SHALL implement FSM with states INIT and RUN; reset enters INIT with fill index 0.
REQ-017 In INIT SHALL write FILL_WORD to mem[idx] each cycle, idx+1; after writing idx=DEPTH-1 SHALL enter RUN next cycle (INIT lasts exactly DEPTH cycles).
REQ-018 In INIT: req_ready=0, init_done=0, load_en ignored.
REQ-019 In RUN: req_ready=1 every cycle, init_done=1; RUN exits only via reset.
REQ-020 Fetch accepted when req_valid&&req_ready; word index = req_addr[31:2].
REQ-021 Fetches SHALL be fully pipelined: one acceptance per cycle, rsp_valid asserted exactly READ_LATENCY cycles after acceptance, responses in request order.
REQ-022 Misaligned fetch (req_addr[1:0]!=0) SHALL respond rsp_err=1, rsp_data=FILL_WORD.
REQ-023 Out-of-range fetch (req_addr[31:2]>=DEPTH) SHALL respond rsp_err=1, rsp_data=FILL_WORD; misaligned takes no precedence difference (same response).
REQ-024 Good fetch SHALL respond rsp_err=0, rsp_data=mem[index].
REQ-025 In RUN, load_en SHALL write load_data to mem[load_addr[31:2]] at clock edge; load_addr[1:0] ignored; out-of-range index write dropped, no error.
REQ-026 Fetch and load to same index same cycle: response returns old content (read-before-write); later fetch sees new word.
REQ-027 When rsp_valid=0, rsp_data=0 and rsp_err=0.
REQ-028 Index compare SHALL use full 30-bit req_addr[31:2], never truncated, so aliasing beyond DEPTH is impossible.

Reset
REQ-029 rst_n low SHALL immediately force rsp_valid=0, rsp_err=0, rsp_data=0, req_ready=0, init_done=0, pipeline valids cleared, FSM=INIT, idx=0.
REQ-030 Reset mid-INIT or mid-RUN SHALL discard in-flight responses and restart full fill from index 0 after rst_n rises; previously loaded program is overwritten.
REQ-031 No response SHALL be emitted for any request presented while rst_n low or in INIT.

Verification (DEPTH=16 unless stated)
REQ-032 Release reset, req_valid=1 held -> req_ready=0 for 16 cycles, init_done and req_ready rise cycle 17; fetch addr 0x0 -> rsp_data=0x00000013, rsp_err=0.
REQ-033 Load 0x00001137 @0x0, 0x00116113 @0x4, then fetch 0x0,0x4 back-to-back, LAT=1 -> rsp 0x00001137, 0x00116113 on consecutive cycles; repeat LAT=2 -> same words, one cycle later.
REQ-034 Fetch 0x2 -> rsp_err=1, rsp_data=0x00000013; fetch 0x40 (index 16) -> rsp_err=1; load to 0x40 then fetch 0x0 -> mem[0] unchanged.
REQ-035 Same cycle load 0xDEADBEEF @0x8 and fetch 0x8 (mem[2]=NOP) -> rsp 0x00000013; next fetch 0x8 -> 0xDEADBEEF.
REQ-036 Assert rst_n low with two fetches in flight (LAT=2) -> rsp_valid=0 immediately, no late response; after release, 16-cycle INIT, mem[0]=0x00000013.
REQ-037 DEPTH=512 stream of 512 sequential fetches -> 512 responses, correct order, zero gaps, rsp_err=0 throughout.
